// File: rtl/usb_fifo_ram.sv
// Simple dual-port byte RAM for the CDC receive buffer: synchronous write, registered read.
// Contents are deliberately not reset so the array maps onto block RAM.
module usb_fifo_ram #(
  parameter int unsigned ASIZE = 10
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [ASIZE-1:0] wr_addr,
  input  logic [7:0]       wr_data,
  input  logic             rd_en,
  input  logic [ASIZE-1:0] rd_addr,
  output logic [7:0]       rd_data
);

  localparam int unsigned Depth = 1 << ASIZE;

  logic [7:0] mem [Depth];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/usb_cdc_rx_fifo.sv
// Receive buffer between a USB FS OUT endpoint strobe and a ready/valid user port.
// Read path: sync-read RAM stage, output register and one-entry skid register.
module usb_cdc_rx_fifo #(
  parameter int unsigned ASIZE       = 10,
  parameter int unsigned AFULL_LEVEL = 960
) (
  input  logic             clk,
  input  logic             usb_rstn,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  output logic [7:0]       out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ASIZE:0]   level,
  output logic             almost_full,
  output logic             overflow,
  output logic [15:0]      drop_count,
  input  logic             clr_overflow
);

  localparam logic [ASIZE:0] Depth  = {1'b1, {ASIZE{1'b0}}};
  localparam logic [ASIZE:0] PtrOne = {{ASIZE{1'b0}}, 1'b1};

  logic [ASIZE:0] wptr_q, rptr_q, level_q;
  logic           r1_valid_q, r1_bypass_q;
  logic [7:0]     byp_data_q;
  logic           out_valid_q, out_valid_d;
  logic [7:0]     out_data_q, out_data_d;
  logic           skid_valid_q, skid_valid_d;
  logic [7:0]     skid_data_q, skid_data_d;
  logic           overflow_q;
  logic [15:0]    drop_count_q;

  logic           wr_en, drop, pop, rd_en, rd_bypass, stored;
  logic [1:0]     occ;
  logic [7:0]     ram_rd_data, r1_data;
  logic [31:0]    level_ext;

  // Full is judged on the registered level only; a same-cycle transfer frees nothing.
  assign wr_en     = in_valid && (level_q != Depth);
  assign drop      = in_valid && (level_q == Depth);
  assign pop       = out_valid_q && out_ready;
  assign stored    = (wptr_q != rptr_q) || wr_en;
  assign rd_bypass = (wptr_q == rptr_q);

  // Entries held downstream after this cycle; a read issued now lands next cycle and
  // must be absorbable by the output/skid pair even if the user stalls.
  assign occ   = 2'(out_valid_q) + 2'(skid_valid_q) + 2'(r1_valid_q) - 2'(pop);
  assign rd_en = stored && (occ <= 2'd1);

  // A read of the slot being written this cycle takes the byte straight from in_data.
  assign r1_data = r1_bypass_q ? byp_data_q : ram_rd_data;

  usb_fifo_ram #(
    .ASIZE(ASIZE)
  ) u_ram (
    .clk    (clk),
    .wr_en  (wr_en),
    .wr_addr(wptr_q[ASIZE-1:0]),
    .wr_data(in_data),
    .rd_en  (rd_en),
    .rd_addr(rptr_q[ASIZE-1:0]),
    .rd_data(ram_rd_data)
  );

  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    if (!out_valid_q || pop) begin
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_data_d   = skid_data_q;
        skid_valid_d = r1_valid_q;
        skid_data_d  = r1_data;
      end else if (r1_valid_q) begin
        out_valid_d = 1'b1;
        out_data_d  = r1_data;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (r1_valid_q) begin
      skid_valid_d = 1'b1;
      skid_data_d  = r1_data;
    end
  end

  always_ff @(posedge clk or negedge usb_rstn) begin
    if (!usb_rstn) begin
      wptr_q       <= '0;
      rptr_q       <= '0;
      level_q      <= '0;
      r1_valid_q   <= 1'b0;
      r1_bypass_q  <= 1'b0;
      byp_data_q   <= 8'h00;
      out_valid_q  <= 1'b0;
      out_data_q   <= 8'h00;
      skid_valid_q <= 1'b0;
      skid_data_q  <= 8'h00;
      overflow_q   <= 1'b0;
      drop_count_q <= 16'h0000;
    end else begin
      if (wr_en) wptr_q <= wptr_q + PtrOne;
      if (rd_en) begin
        rptr_q      <= rptr_q + PtrOne;
        r1_bypass_q <= rd_bypass;
        byp_data_q  <= in_data;
      end
      r1_valid_q <= rd_en;
      unique case ({wr_en, pop})
        2'b10:   level_q <= level_q + PtrOne;
        2'b01:   level_q <= level_q - PtrOne;
        default: level_q <= level_q;
      endcase
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      if (clr_overflow) begin
        overflow_q   <= drop;
        drop_count_q <= {15'h0000, drop};
      end else if (drop) begin
        overflow_q <= 1'b1;
        if (drop_count_q != 16'hFFFF) drop_count_q <= drop_count_q + 16'h0001;
      end
    end
  end

  assign level_ext   = 32'(level_q);
  assign level       = level_q;
  assign almost_full = level_ext >= AFULL_LEVEL;
  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign overflow    = overflow_q;
  assign drop_count  = drop_count_q;

endmodule
